// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit: program-ROM reader. Owns the PC, drives the ROM address,
// captures the returned word into the instruction register and resolves
// GOTO / CALL / RETURN / RETFIE / RETLW / skip / computed jumps locally with
// a circular hardware return stack.
//
// Optional feature macro: FETCH_STACK_ERR_EN
//   defined   -> an occupancy counter tracks the return stack and drives the
//                sticky stack_ovf / stack_unf flags.
//   undefined -> no counter; stack_ovf / stack_unf tied to 0. The stack still
//                wraps circularly and PC behaviour is identical.
//
// Output handshake: there is no backpressure on the instruction register.
// Every cycle without stall presents a new ir_out; ir_valid=1 marks a real
// instruction, ir_valid=0 marks a flushed bubble (ir_out=0, a NOP) whose
// ir_pc_out holds the address that will be (or would have been) fetched.
// While stall=1 all outputs hold their previous value.
module prog_fetch_unit #(
    parameter int STACK_DEPTH = 8,
    parameter int PC_W        = 11,
    parameter int IW          = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] rom_addr_out,
    input  logic [IW-1:0]   rom_data_in,
    input  logic            stall,
    input  logic            skip_req,
    input  logic            pc_load_en,
    input  logic [PC_W-1:0] pc_load_val,
    output logic [IW-1:0]   ir_out,
    output logic [PC_W-1:0] ir_pc_out,
    output logic            ir_valid,
    output logic            stack_ovf,
    output logic            stack_unf
);

    localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [SP_W-1:0] sp_m1;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];

    logic            is_goto;
    logic            is_call;
    logic            is_ret;
    logic            push;
    logic            pop;
    logic            redirect;
    logic [PC_W-1:0] target;

    // Decode the held instruction; bubbles never decode as control ops.
    always_comb begin
        is_goto = ir_valid_q && (ir_q[IW-1:IW-3] == 3'b101);
        is_call = ir_valid_q && (ir_q[IW-1:IW-3] == 3'b100);
        is_ret  = ir_valid_q && ((ir_q == IW'(14'h0008)) ||
                                 (ir_q == IW'(14'h0009)) ||
                                 (ir_q[IW-1:IW-4] == 4'b1101));
    end

    assign sp_m1 = sp_q - SP_W'(1);

    // Next-state selection in priority order: stall, computed load, GOTO,
    // CALL, return family, skip, sequential fetch.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        sp_d       = sp_q;
        push       = 1'b0;
        pop        = 1'b0;
        redirect   = 1'b0;
        target     = '0;
        if (!stall) begin
            if (pc_load_en) begin
                redirect = 1'b1;
                target   = pc_load_val;
            end else if (is_goto) begin
                redirect = 1'b1;
                target   = ir_q[PC_W-1:0];
            end else if (is_call) begin
                redirect = 1'b1;
                push     = 1'b1;
                target   = ir_q[PC_W-1:0];
                sp_d     = sp_q + SP_W'(1);
            end else if (is_ret) begin
                redirect = 1'b1;
                pop      = 1'b1;
                target   = stack_q[sp_m1];
                sp_d     = sp_m1;
            end

            if (redirect) begin
                // Drop the word fetched this cycle; fetch the target next.
                ir_d       = '0;
                ir_valid_d = 1'b0;
                ir_pc_d    = target;
                pc_d       = target;
            end else if (skip_req) begin
                ir_d       = '0;
                ir_valid_d = 1'b0;
                ir_pc_d    = pc_q;
                pc_d       = pc_q + PC_W'(1);
            end else begin
                ir_d       = rom_data_in;
                ir_valid_d = 1'b1;
                ir_pc_d    = pc_q;
                pc_d       = pc_q + PC_W'(1);
            end
        end
    end

    // Fetch pipeline and stack pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            sp_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            sp_q       <= sp_d;
        end
    end

    // Return-stack storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q] <= pc_q;
        end
    end

`ifdef FETCH_STACK_ERR_EN
    localparam logic [SP_W:0] CNT_MAX = (SP_W+1)'(STACK_DEPTH);

    logic [SP_W:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // Saturating occupancy count and sticky error flags.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (SP_W+1)'(1);
            end
        end else if (pop) begin
            if (cnt_q == '0) begin
                unf_d = 1'b1;
            end else begin
                cnt_d = cnt_q - (SP_W+1)'(1);
            end
        end
    end

    // Error tracker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    assign rom_addr_out = pc_q;
    assign ir_out       = ir_q;
    assign ir_pc_out    = ir_pc_q;
    assign ir_valid     = ir_valid_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Bench for prog_fetch_unit: directed program scenarios followed by a
// randomized program and random stall/skip/load traffic, all predicted by a
// behavioural fetch model and checked through an expected queue.
module tb_prog_fetch_unit;

    localparam int DEPTH = 8;
`ifdef FETCH_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [13:0] ir;
        logic [10:0] ir_pc;
        logic        v;
        logic [10:0] addr;
        logic        ovf;
        logic        unf;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] rom_addr_out;
    logic [13:0] rom_data_in;
    logic        stall = 1'b0;
    logic        skip_req = 1'b0;
    logic        pc_load_en = 1'b0;
    logic [10:0] pc_load_val = '0;
    logic [13:0] ir_out;
    logic [10:0] ir_pc_out;
    logic        ir_valid;
    logic        stack_ovf;
    logic        stack_unf;

    logic [13:0] rom [2048];
    obs_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    // Behavioural model state
    int m_pc, m_ir, m_irpc, m_sp, m_cnt;
    bit m_v, m_ovf, m_unf;
    int m_stack [DEPTH];

    prog_fetch_unit #(.STACK_DEPTH(DEPTH), .PC_W(11), .IW(14)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_addr_out(rom_addr_out),
        .rom_data_in (rom_data_in),
        .stall       (stall),
        .skip_req    (skip_req),
        .pc_load_en  (pc_load_en),
        .pc_load_val (pc_load_val),
        .ir_out      (ir_out),
        .ir_pc_out   (ir_pc_out),
        .ir_valid    (ir_valid),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    assign rom_data_in = rom[rom_addr_out];

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: one clock of the fetch unit from program-level rules.
    function automatic void model_step(input bit st, input bit sk, input bit ld, input int ldv);
        int tgt;
        int op3;
        bit is_ret;
        if (!st) begin
            tgt = -1;
            op3 = m_ir / 2048;
            is_ret = m_v && (m_ir == 8 || m_ir == 9 || (m_ir / 1024) == 13);
            if (ld) begin
                tgt = ldv;
            end else if (m_v && op3 == 5) begin
                tgt = m_ir % 2048;
            end else if (m_v && op3 == 4) begin
                if (m_cnt == DEPTH) m_ovf = 1;
                m_stack[m_sp] = m_pc;
                m_sp = (m_sp + 1) % DEPTH;
                m_cnt = (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
                tgt = m_ir % 2048;
            end else if (is_ret) begin
                if (m_cnt == 0) m_unf = 1;
                m_sp = (m_sp + DEPTH - 1) % DEPTH;
                tgt = m_stack[m_sp];
                m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
            end
            if (tgt >= 0) begin
                m_ir = 0; m_v = 0; m_irpc = tgt; m_pc = tgt;
            end else if (sk) begin
                m_ir = 0; m_v = 0; m_irpc = m_pc; m_pc = (m_pc + 1) % 2048;
            end else begin
                m_ir = int'(rom[m_pc]); m_v = 1; m_irpc = m_pc; m_pc = (m_pc + 1) % 2048;
            end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.ir    = 14'(m_ir);
        o.ir_pc = 11'(m_irpc);
        o.v     = m_v;
        o.addr  = 11'(m_pc);
        o.ovf   = ERR_EN & m_ovf;
        o.unf   = ERR_EN & m_unf;
        return o;
    endfunction

    // Monitor: every clock after reset release the DUT presents a new state.
    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{ir: ir_out, ir_pc: ir_pc_out, v: ir_valid, addr: rom_addr_out,
                   ovf: stack_ovf, unf: stack_unf};
            n_chk++;
            if (a !== e) begin
                n_err++;
                $display("FAIL scoreboard @%0t: got ir=%h pc=%h v=%b addr=%h ovf=%b unf=%b, expected ir=%h pc=%h v=%b addr=%h ovf=%b unf=%b",
                         $time, a.ir, a.ir_pc, a.v, a.addr, a.ovf, a.unf,
                         e.ir, e.ir_pc, e.v, e.addr, e.ovf, e.unf);
            end
        end
    end

    // Driver: one clock of stimulus, with the model prediction queued.
    task automatic cycle(input bit st, input bit sk, input bit ld, input int ldv);
        @(negedge clk);
        stall = st; skip_req = sk; pc_load_en = ld; pc_load_val = 11'(ldv);
        model_step(st, sk, ld, ldv);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    // Asynchronous reset away from any clock edge; stack contents persist.
    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        stall = 0; skip_req = 0; pc_load_en = 0; pc_load_val = '0;
        #1;
        chk("rst_ir", int'(ir_out), 0);
        chk("rst_ir_pc", int'(ir_pc_out), 0);
        chk("rst_valid", int'(ir_valid), 0);
        chk("rst_addr", int'(rom_addr_out), 0);
        chk("rst_ovf", int'(stack_ovf), 0);
        chk("rst_unf", int'(stack_unf), 0);
        m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0; m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [13:0] rand_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 8)  return 14'h2800 | 14'($urandom_range(0, 2047));
        if (r < 16) return 14'h2000 | 14'($urandom_range(0, 2047));
        if (r < 22) return 14'h0008;
        if (r < 25) return 14'h0009;
        if (r < 30) return 14'h3400 | 14'($urandom_range(0, 1023));
        r = $urandom_range(0, 4095);
        if (r == 8 || r == 9) r = 0;
        return 14'(r);
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = '0;
        rom[0] = 14'h01A5; rom[1] = 14'h0103; rom[2] = 14'h3007;
        rom[5] = 14'h3055; rom[6] = 14'h3066;
        rom[11'h00B] = 14'h280B;
        rom[11'h010] = 14'h2050; rom[11'h011] = 14'h3011;
        rom[11'h050] = 14'h0008;
        for (int i = 0; i < 9; i++) rom[11'h100 + i] = 14'(14'h2000 + 11'h101 + i);
        rom[11'h180] = 14'h0008;
        rom[11'h030] = 14'h2820;
        for (int i = 0; i < DEPTH; i++) m_stack[i] = 0;

        // First fetches after reset
        do_reset();
        cycle(0, 0, 0, 0);
        chk("first_ir", int'(ir_out), 'h01A5);
        chk("first_ir_pc", int'(ir_pc_out), 0);
        chk("first_valid", int'(ir_valid), 1);
        chk("first_addr", int'(rom_addr_out), 1);
        cycle(0, 0, 0, 0);
        chk("second_ir", int'(ir_out), 'h0103);

        // Skip, with and without stall
        do_reset();
        run(5);
        cycle(1, 1, 0, 0);
        chk("stall_skip_pc", int'(ir_pc_out), 4);
        chk("stall_skip_valid", int'(ir_valid), 1);
        cycle(0, 1, 0, 0);
        chk("skip_bubble", int'(ir_valid), 0);
        cycle(0, 0, 0, 0);
        chk("after_skip_pc", int'(ir_pc_out), 6);
        chk("after_skip_ir", int'(ir_out), 'h3066);

        // GOTO self-loop
        do_reset();
        run(12);
        cycle(0, 0, 0, 0);
        chk("goto_bubble", int'(ir_valid), 0);
        chk("goto_addr_b", int'(rom_addr_out), 'h00B);
        cycle(0, 0, 0, 0);
        chk("goto_ir", int'(ir_out), 'h280B);
        chk("goto_addr_c", int'(rom_addr_out), 'h00C);
        cycle(0, 0, 0, 0);
        chk("goto_addr_b2", int'(rom_addr_out), 'h00B);

        // CALL / RETURN
        do_reset();
        cycle(0, 0, 1, 'h010);
        run(5);
        chk("ret_resume_pc", int'(ir_pc_out), 'h011);
        chk("ret_resume_valid", int'(ir_valid), 1);
        chk("ret_no_ovf", int'(stack_ovf), 0);
        chk("ret_no_unf", int'(stack_unf), 0);

        // Nine nested calls, then nine returns
        do_reset();
        cycle(0, 0, 1, 'h100);
        run(22);
        chk("nest_ovf", int'(stack_ovf), int'(ERR_EN));
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1, 'h180);
            run(2);
            if (i == 7) chk("unf_after_8", int'(stack_unf), 0);
        end
        chk("unf_after_9", int'(stack_unf), int'(ERR_EN));

        // Computed load beats GOTO, then PC wraps
        do_reset();
        cycle(0, 0, 1, 'h030);
        cycle(0, 0, 0, 0);
        chk("goto_held", int'(ir_out), 'h2820);
        cycle(0, 0, 1, 'h7FF);
        chk("load_wins_pc", int'(ir_pc_out), 'h7FF);
        cycle(0, 0, 0, 0);
        chk("wrap_addr", int'(rom_addr_out), 0);
        cycle(0, 0, 0, 0);
        chk("wrap_ir_pc", int'(ir_pc_out), 0);

        // Random program and random control traffic
        for (int i = 0; i < 2048; i++) rom[i] = rand_word();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 750 == 749) do_reset();
            cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 5, int'($urandom_range(0, 2047)));
        end

        // Drain the expected queue with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
